// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: issues one lane per cycle to a scalar ALU and captures results.
// Optional lane-flag reduction outputs are enabled by VECTOR_ALU_SEQ_REDUCE_EN.
module vector_alu_sequencer #(
  parameter int WIDTH = 4,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [LANES*WIDTH-1:0] vec_a,
  input  logic [LANES*WIDTH-1:0] vec_b,
  output logic                   busy,
  output logic                   done,
  output logic [LANES*WIDTH-1:0] vec_result,
  output logic [LANES*4-1:0]     vec_flags,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [1:0]             alu_ctrl,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic [3:0]             alu_flags
`ifdef VECTOR_ALU_SEQ_REDUCE_EN
  ,
  output logic                   all_zero,
  output logic                   any_carry,
  output logic                   any_overflow
`endif
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]          idx;
  logic [IW-1:0]          sel;
  logic [LANES*WIDTH-1:0] a_lat;
  logic [LANES*WIDTH-1:0] b_lat;
  logic [1:0]             op_lat;
  logic                   last;
  logic                   accept;

  assign last   = (state == RUN) && (idx == IW'(LANES - 1));
  assign accept = (state == IDLE) && start;

  // Outside RUN the bus parks on latched lane 0 so it never follows live inputs.
  assign sel      = (state == RUN) ? idx : '0;
  assign alu_a    = a_lat[int'(sel)*WIDTH +: WIDTH];
  assign alu_b    = b_lat[int'(sel)*WIDTH +: WIDTH];
  assign alu_ctrl = op_lat;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      op_lat     <= 2'b00;
      vec_result <= '0;
      vec_flags  <= '0;
    end else if (accept) begin
      idx        <= '0;
      a_lat      <= vec_a;
      b_lat      <= vec_b;
      op_lat     <= op;
      vec_result <= '0;
      vec_flags  <= '0;
    end else if (state == RUN) begin
      vec_result[int'(idx)*WIDTH +: WIDTH] <= alu_result;
      vec_flags[int'(idx)*4 +: 4]          <= alu_flags;
      if (!last) idx <= idx + 1'b1;
    end
  end

`ifdef VECTOR_ALU_SEQ_REDUCE_EN
  logic z_acc;
  logic c_acc;
  logic v_acc;

  // Earlier lanes are already captured; the final lane comes live from the ALU.
  always_comb begin
    z_acc = alu_flags[2];
    c_acc = alu_flags[1];
    v_acc = alu_flags[0];
    for (int i = 0; i < LANES - 1; i++) begin
      z_acc = z_acc & vec_flags[i*4+2];
      c_acc = c_acc | vec_flags[i*4+1];
      v_acc = v_acc | vec_flags[i*4+0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      all_zero     <= 1'b0;
      any_carry    <= 1'b0;
      any_overflow <= 1'b0;
    end else if (last) begin
      all_zero     <= z_acc;
      any_carry    <= c_acc;
      any_overflow <= v_acc;
    end
  end
`endif

endmodule
